fp_mul_driver: RTL and testbench
================================

# fp_mul_driver

Initiator-side sequencer for the 32-bit floating-point multiplier's start/done handshake. It buffers operand pairs in a small FIFO and drives `start` with stable operands, one operation at a time. It detects completion on the rising edge of `done`, captures product and exception flags, and presents them on a valid/ready output port. It sits between an upstream operand source and the `multiplier32FP` instance, replacing bench-side sequencing in system-level integrations.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries; power of two, 2..16.
- `TIMEOUT`, 64: maximum cycles to wait for `done` (used only with `FPMUL_DRV_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid_i` in 1: operand pair valid.
- `in_ready_o` out 1: FIFO not full.
- `a_i`, `b_i` in 32 each: IEEE-754 single operands.
- `mul_a_o`, `mul_b_o` out 32 each: operands to the multiplier.
- `mul_start_o` out 1: start level to the multiplier.
- `mul_done_i` in 1: multiplier done.
- `mul_nan_i`, `mul_inf_i`, `mul_ovf_i`, `mul_unf_i` in 1 each: multiplier exception flags.
- `mul_product_i` in 32: multiplier product.
- `out_valid_o` out 1: result held valid.
- `out_ready_i` in 1: consumer accepts result.
- `out_product_o` out 32: captured product.
- `out_flags_o` out 5: {timeout, nan, inf, overflow, underflow}.
- `busy_o` out 1: state != IDLE or FIFO non-empty.

## Operation
FIFO:
- Push when `in_valid_i && in_ready_o`.
- `in_ready_o = (count != DEPTH)`. A pop in the same cycle does not free the slot for a push in that cycle.
- `count` ranges 0..DEPTH. Read and write pointers wrap modulo DEPTH.

Done edge detection:
- `done_q` registers `mul_done_i`.
- `done_rise = mul_done_i && !done_q`.

FSM states are IDLE, ISSUE, RESULT.
- IDLE:
  - If FIFO non-empty, pop the head into `mul_a_o`/`mul_b_o` and go to ISSUE.
  - `mul_start_o` is 0.
- ISSUE:
  - `mul_start_o` is 1.
  - `mul_a_o`/`mul_b_o` are frozen.
  - On `done_rise`, capture `mul_product_i` and the four flags into the output register and go to RESULT.
  - A `done` already high on entry is ignored until it falls and rises again.
- RESULT:
  - `out_valid_o` is 1 and `mul_start_o` is 0.
  - On `out_ready_i`, go to IDLE.
  - The output register is not overwritten while `out_valid_o` is 1.

Rules:
- Only one operation is ever in flight.
- Results emerge in push order.
- Outputs other than `out_*` carry no meaning outside their states.
- Reset mid-operation:
  - Flushes the FIFO and drops any in-flight result.
  - A `done` arriving later is ignored unless the FSM is in ISSUE.

## Timing
Reset values:
- `in_ready_o` = 1.
- `mul_start_o`, `out_valid_o` and `busy_o` = 0.
- `mul_a_o`, `mul_b_o`, `out_product_o` and `out_flags_o` = 0.
- `count`, pointers, `done_q` and the timeout counter = 0. State = IDLE.

Latency:
- Pair pushed at cycle N into an empty FIFO in IDLE → `mul_start_o` high at N+2 (pop at N+1, ISSUE from N+2).
- `done_rise` sampled at cycle M → `out_valid_o` high at M+1.
- `out_ready_i` at cycle R with FIFO non-empty → next `mul_start_o` at R+2.

Throughput: one result per multiplier latency + 3 cycles.

## Configuration
Macro `FPMUL_DRV_TIMEOUT_EN`.

Defined:
- An 8-bit counter clears on entry to ISSUE and increments each cycle in ISSUE.
- When it reaches `TIMEOUT` without `done_rise`, go to RESULT with:
  - `out_product_o` = 0x7FC00000;
  - `out_flags_o` = 5'b1_0000.
- `done_rise` in the same cycle as the limit wins: a normal capture with timeout = 0.

Not defined:
- No counter is built.
- `out_flags_o[4]` is tied to 0.
- ISSUE waits indefinitely.

## Test plan
- Basic multiply: push 0x40400000 × 0x40000000; model asserts `done` 5 cycles after start → `out_product_o` = 0x40C00000, flags = 0, `out_valid_o` 1 cycle after `done` rise.
- FIFO full: push 5 pairs back-to-back at DEPTH=4 with the multiplier stalled → `in_ready_o` low after the 4th push; results emerge in push order once `done` pulses resume.
- NaN flag: 0x7FC00000 × 0x3F800000, model raises `mul_nan_i` with `done` → `out_flags_o` = 5'b0_1000, product 0x7FC00000.
- Stale done: `mul_done_i` held high from before start → no capture until `done` falls and rises; output backpressure (`out_ready_i` low 10 cycles) keeps product stable and `mul_start_o` low.
- Timeout (macro on, TIMEOUT=64): `done` never rises → `out_valid_o` at ISSUE entry + 65, flags 5'b1_0000; a second run with `done` on the limit cycle → normal result.
- Reset mid-ISSUE with 2 entries queued → all outputs return to reset values next cycle, `count` = 0, and a late `done` produces no output.

Source files
------------

// File: rtl/fp_mul_driver.sv
// fp_mul_driver: start/done sequencer for the 32-bit FP multiplier with an operand FIFO and a valid/ready result port.
// Optional done watchdog: define FPMUL_DRV_TIMEOUT_EN to abort ISSUE after TIMEOUT cycles with a quiet-NaN result.
module fp_mul_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_start_o,
  input  logic        mul_done_i,
  input  logic        mul_nan_i,
  input  logic        mul_inf_i,
  input  logic        mul_ovf_i,
  input  logic        mul_unf_i,
  input  logic [31:0] mul_product_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_product_o,
  output logic [4:0]  out_flags_o,
  output logic        busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESULT} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  state_t           state;
  state_t           state_nxt;
  pair_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             done_q;
  logic             done_rise;
  logic             push;
  logic             pop;
  logic             capture;

`ifdef FPMUL_DRV_TIMEOUT_EN
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  logic [7:0] timer;
  logic       expire;
`else
  logic       unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign push      = in_valid_i && in_ready_o;
  assign done_rise = mul_done_i && !done_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle actions
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
`ifdef FPMUL_DRV_TIMEOUT_EN
    expire    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (done_rise) begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end
`ifdef FPMUL_DRV_TIMEOUT_EN
        else if (timer == 8'(TIMEOUT)) begin
          expire    = 1'b1;
          state_nxt = RESULT;
        end
`endif
      end
      RESULT: begin
        if (out_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO occupancy; a pop never frees a slot for a push in the same cycle
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: a_i, b: b_i};
    end
  end

  // Registered datapath and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      done_q        <= 1'b0;
      in_ready_o    <= 1'b1;
      busy_o        <= 1'b0;
      mul_start_o   <= 1'b0;
      mul_a_o       <= '0;
      mul_b_o       <= '0;
      out_valid_o   <= 1'b0;
      out_product_o <= '0;
      out_flags_o   <= '0;
    end else begin
      done_q      <= mul_done_i;
      count       <= count_nxt;
      in_ready_o  <= (count_nxt != CNT_W'(DEPTH));
      busy_o      <= (state_nxt != IDLE) || (count_nxt != '0);
      mul_start_o <= (state_nxt == ISSUE);
      out_valid_o <= (state_nxt == RESULT);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        mul_a_o <= mem[rd_ptr].a;
        mul_b_o <= mem[rd_ptr].b;
      end
      if (capture) begin
        out_product_o <= mul_product_i;
        out_flags_o   <= {1'b0, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i};
      end
`ifdef FPMUL_DRV_TIMEOUT_EN
      if (expire) begin
        out_product_o <= QNAN;
        out_flags_o   <= 5'b1_0000;
      end
`endif
    end
  end

`ifdef FPMUL_DRV_TIMEOUT_EN
  // Wait-for-done counter, restarted on every entry to ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (pop) begin
      timer <= '0;
    end else if (state == ISSUE) begin
      timer <= timer + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_driver.sv
// Self-checking bench for fp_mul_driver: behavioural multiplier responder plus an in-order result queue.
module tb_fp_mul_driver;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [31:0] mul_a_o;
  logic [31:0] mul_b_o;
  logic        mul_start_o;
  logic        mul_done_i;
  logic        mul_nan_i;
  logic        mul_inf_i;
  logic        mul_ovf_i;
  logic        mul_unf_i;
  logic [31:0] mul_product_i;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_product_o;
  logic [4:0]  out_flags_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] exp_q [$];

  // Multiplier responder (automatic) and direct overrides (forced) from the tests
  logic        m_en = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_wait = 1'b0;
  int unsigned m_lat = 3;
  int unsigned m_cnt = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_product = '0;
  logic [3:0]  m_flags = '0;
  logic        f_done = 1'b0;
  logic [31:0] f_product = '0;
  logic [3:0]  f_flags = '0;

  fp_mul_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .a_i(a_i), .b_i(b_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_start_o(mul_start_o), .mul_done_i(mul_done_i),
    .mul_nan_i(mul_nan_i), .mul_inf_i(mul_inf_i), .mul_ovf_i(mul_ovf_i), .mul_unf_i(mul_unf_i),
    .mul_product_i(mul_product_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_product_o(out_product_o),
    .out_flags_o(out_flags_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Multiplier behaviour: {nan, inf, ovf, unf, product}
  function automatic logic [35:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4040_0000 && b == 32'h4000_0000) return {4'b0000, 32'h40C0_0000};
    if (a == 32'h7FC0_0000 || b == 32'h7FC0_0000) return {4'b1000, 32'h7FC0_0000};
    return {a[3:0] ^ b[7:4], a ^ {b[15:0], b[31:16]}};
  endfunction

  assign mul_done_i = m_done | f_done;
  assign {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i, mul_product_i} =
    f_done ? {f_flags, f_product} : {m_flags, m_product};

  always @(posedge clk) begin
    if (rst || !m_en) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
      m_wait <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_wait) begin
        if (!mul_start_o) m_wait <= 1'b0;
      end else if (m_busy) begin
        if (!m_hold) begin
          if (m_cnt == 0) begin
            m_done <= 1'b1;
            {m_flags, m_product} <= mul_model(m_a, m_b);
            m_busy <= 1'b0;
            m_wait <= 1'b1;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
      end else if (mul_start_o) begin
        m_busy <= 1'b1;
        m_cnt  <= m_lat;
        m_a    <= mul_a_o;
        m_b    <= mul_b_o;
      end
    end
  end

  // Offer one pair (called at a negedge); returns at the negedge after acceptance
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input bit track, output bit ok);
    ok = 1'b0;
    in_valid_i = 1'b1;
    a_i = a;
    b_i = b;
    for (int t = 0; t < 400 && !ok; t++) begin
      if (in_ready_o === 1'b1) begin
        ok = 1'b1;
        if (track) exp_q.push_back({1'b0, mul_model(a, b)});
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready_o); end
    n_cmp++; if ({mul_start_o, out_valid_o, busy_o} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: got %b, expected 000", {mul_start_o, out_valid_o, busy_o}); end
    n_cmp++; if ({mul_a_o, mul_b_o} !== 64'h0) begin n_bad++; $display("FAIL reset_operands: got %h, expected 0", {mul_a_o, mul_b_o}); end
    n_cmp++; if ({out_flags_o, out_product_o} !== 37'h0) begin n_bad++; $display("FAIL reset_result: got %h, expected 0", {out_flags_o, out_product_o}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy_o, in_ready_o} !== 2'b01) begin n_bad++; $display("FAIL reset_release: got %b, expected 01", {busy_o, in_ready_o}); end
  endtask

  task automatic test_basic();
    m_en = 1'b1; m_hold = 1'b0; m_lat = 3; out_ready_i = 1'b0;
    a_i = 32'h4040_0000; b_i = 32'h4000_0000; in_valid_i = 1'b1;
    n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b, expected 1", in_ready_o); end
    @(negedge clk);
    in_valid_i = 1'b0;
    n_cmp++; if (mul_start_o !== 1'b0) begin n_bad++; $display("FAIL basic_start_early: got %b, expected 0", mul_start_o); end
    @(negedge clk);
    n_cmp++; if ({mul_start_o, mul_a_o, mul_b_o} !== {1'b1, 32'h4040_0000, 32'h4000_0000})
      begin n_bad++; $display("FAIL basic_issue: got %h, expected %h", {mul_start_o, mul_a_o, mul_b_o}, {1'b1, 32'h4040_0000, 32'h4000_0000}); end
    for (int t = 0; t < 40 && mul_done_i !== 1'b1; t++) @(negedge clk);
    n_cmp++; if ({mul_done_i, out_valid_o} !== 2'b10) begin n_bad++; $display("FAIL basic_done_cycle: got %b, expected 10", {mul_done_i, out_valid_o}); end
    @(negedge clk);
    n_cmp++; if ({out_valid_o, out_flags_o, out_product_o} !== {1'b1, 5'b0, 32'h40C0_0000})
      begin n_bad++; $display("FAIL basic_result: got %h, expected %h", {out_valid_o, out_flags_o, out_product_o}, {1'b1, 5'b0, 32'h40C0_0000}); end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    n_cmp++; if ({out_valid_o, busy_o} !== 2'b00) begin n_bad++; $display("FAIL basic_drain: got %b, expected 00", {out_valid_o, busy_o}); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] blk_a, blk_b;
    logic [36:0] exp;
    bit ok, acc;
    int got;
    m_en = 1'b1; m_hold = 1'b1; m_lat = 2; out_ready_i = 1'b0;
    blk_a = $urandom; blk_b = $urandom;
    push_pair(blk_a, blk_b, 1'b1, ok);
    for (int t = 0; t < 10 && mul_start_o !== 1'b1; t++) @(negedge clk);
    n_cmp++; if ({ok, mul_start_o} !== 2'b11) begin n_bad++; $display("FAIL full_blocker: got %b, expected 11", {ok, mul_start_o}); end
    for (int i = 0; i < 5; i++) begin
      a_i = $urandom; b_i = $urandom; in_valid_i = 1'b1;
      n_cmp++; if (in_ready_o !== 1'(i < 4)) begin n_bad++; $display("FAIL full_ready[%0d]: got %b, expected %b", i, in_ready_o, 1'(i < 4)); end
      if (in_ready_o === 1'b1) exp_q.push_back({1'b0, mul_model(a_i, b_i)});
      if (i < 4) @(negedge clk);
    end
    n_cmp++; if ({busy_o, mul_a_o, mul_b_o} !== {1'b1, blk_a, blk_b})
      begin n_bad++; $display("FAIL full_frozen: got %h, expected %h", {busy_o, mul_a_o, mul_b_o}, {1'b1, blk_a, blk_b}); end
    m_hold = 1'b0; out_ready_i = 1'b1;
    got = 0;
    for (int t = 0; t < 400 && got < 6; t++) begin
      if (out_valid_o === 1'b1) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++; if ({out_flags_o, out_product_o} !== exp) begin n_bad++; $display("FAIL full_order[%0d]: got %h, expected %h", got, {out_flags_o, out_product_o}, exp); end
        got++;
      end
      acc = in_valid_i && in_ready_o;
      if (acc) exp_q.push_back({1'b0, mul_model(a_i, b_i)});
      @(negedge clk);
      if (acc) in_valid_i = 1'b0;
    end
    out_ready_i = 1'b0;
    n_cmp++; if (got !== 6) begin n_bad++; $display("FAIL full_count: got %0d, expected 6", got); end
  endtask

  task automatic test_nan();
    bit ok;
    m_en = 1'b1; m_hold = 1'b0; m_lat = 1; out_ready_i = 1'b0;
    push_pair(32'h7FC0_0000, 32'h3F80_0000, 1'b0, ok);
    for (int t = 0; t < 40 && out_valid_o !== 1'b1; t++) @(negedge clk);
    n_cmp++; if ({ok, out_valid_o} !== 2'b11) begin n_bad++; $display("FAIL nan_valid: got %b, expected 11", {ok, out_valid_o}); end
    n_cmp++; if (out_flags_o !== 5'b0_1000) begin n_bad++; $display("FAIL nan_flags: got %b, expected 01000", out_flags_o); end
    n_cmp++; if (out_product_o !== 32'h7FC0_0000) begin n_bad++; $display("FAIL nan_product: got %h, expected 7fc00000", out_product_o); end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  task automatic test_stale_done();
    logic [31:0] p;
    logic [36:0] exp;
    bit ok;
    int got;
    m_en = 1'b0; out_ready_i = 1'b0;
    f_done = 1'b1; f_product = $urandom; f_flags = 4'b1111;
    repeat (2) @(negedge clk);
    push_pair($urandom, $urandom, 1'b0, ok);
    for (int t = 0; t < 10 && mul_start_o !== 1'b1; t++) @(negedge clk);
    n_cmp++; if ({ok, mul_start_o} !== 2'b11) begin n_bad++; $display("FAIL stale_issue: got %b, expected 11", {ok, mul_start_o}); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL stale_ignored[%0d]: got %b, expected 0", i, out_valid_o); end
    end
    f_done = 1'b0;
    @(negedge clk);
    p = $urandom; f_product = p; f_flags = 4'b0101; f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
    n_cmp++; if ({out_valid_o, out_flags_o, out_product_o} !== {1'b1, 5'b0_0101, p})
      begin n_bad++; $display("FAIL stale_capture: got %h, expected %h", {out_valid_o, out_flags_o, out_product_o}, {1'b1, 5'b0_0101, p}); end
    push_pair($urandom, $urandom, 1'b1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stale_push: got %b, expected 1", ok); end
    for (int i = 0; i < 10; i++) begin
      f_product = $urandom; f_done = i[0];
      @(negedge clk);
      n_cmp++; if ({out_valid_o, mul_start_o, out_product_o} !== {1'b1, 1'b0, p})
        begin n_bad++; $display("FAIL stale_hold[%0d]: got %h, expected %h", i, {out_valid_o, mul_start_o, out_product_o}, {1'b1, 1'b0, p}); end
    end
    f_done = 1'b0; m_en = 1'b1; m_lat = 2; out_ready_i = 1'b1;
    got = 0;
    for (int t = 0; t < 100 && got < 1; t++) begin
      @(negedge clk);
      if (out_valid_o === 1'b1) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++; if ({out_flags_o, out_product_o} !== exp) begin n_bad++; $display("FAIL stale_next: got %h, expected %h", {out_flags_o, out_product_o}, exp); end
        got++;
      end
    end
    @(negedge clk);
    out_ready_i = 1'b0;
    n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL stale_next_count: got %0d, expected 1", got); end
  endtask

`ifdef FPMUL_DRV_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] p;
    bit ok;
    int lat;
    m_en = 1'b0; f_done = 1'b0; out_ready_i = 1'b0;
    push_pair($urandom, $urandom, 1'b0, ok);
    for (int t = 0; t < 10 && mul_start_o !== 1'b1; t++) @(negedge clk);
    lat = 0;
    for (int t = 0; t < 100 && out_valid_o !== 1'b1; t++) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL timeout_latency: got %0d, expected 65", lat); end
    n_cmp++; if ({out_flags_o, out_product_o} !== {5'b1_0000, 32'h7FC0_0000})
      begin n_bad++; $display("FAIL timeout_result: got %h, expected %h", {out_flags_o, out_product_o}, {5'b1_0000, 32'h7FC0_0000}); end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    push_pair($urandom, $urandom, 1'b0, ok);
    for (int t = 0; t < 10 && mul_start_o !== 1'b1; t++) @(negedge clk);
    repeat (64) @(negedge clk);
    n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL timeout_limit_early: got %b, expected 0", out_valid_o); end
    p = $urandom; f_product = p; f_flags = 4'b0010; f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
    n_cmp++; if ({out_valid_o, out_flags_o, out_product_o} !== {1'b1, 5'b0_0010, p})
      begin n_bad++; $display("FAIL timeout_done_wins: got %h, expected %h", {out_valid_o, out_flags_o, out_product_o}, {1'b1, 5'b0_0010, p}); end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask
`endif

  task automatic test_random_stream();
    logic [36:0] exp;
    bit acc;
    int pushed, got;
    pushed = 0; got = 0;
    m_en = 1'b1; m_hold = 1'b0; in_valid_i = 1'b0;
    for (int t = 0; t < 4000 && got < 40; t++) begin
      m_lat = $urandom_range(0, 6);
      out_ready_i = ($urandom_range(0, 3) != 0);
      if (out_valid_o === 1'b1 && out_ready_i) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++; if ({out_flags_o, out_product_o} !== exp) begin n_bad++; $display("FAIL stream[%0d]: got %h, expected %h", got, {out_flags_o, out_product_o}, exp); end
        got++;
      end
      acc = in_valid_i && in_ready_o;
      if (acc) begin exp_q.push_back({1'b0, mul_model(a_i, b_i)}); pushed++; end
      @(negedge clk);
      if (acc || !in_valid_i) begin
        in_valid_i = (pushed < 40) && ($urandom_range(0, 2) != 0);
        a_i = $urandom; b_i = $urandom;
      end
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    n_cmp++; if (got !== 40 || exp_q.size() !== 0) begin n_bad++; $display("FAIL stream_count: got %0d left %0d, expected 40 left 0", got, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    m_en = 1'b0; f_done = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) push_pair($urandom, $urandom, 1'b0, ok);
    for (int t = 0; t < 10 && mul_start_o !== 1'b1; t++) @(negedge clk);
    n_cmp++; if ({mul_start_o, busy_o} !== 2'b11) begin n_bad++; $display("FAIL rstmid_issue: got %b, expected 11", {mul_start_o, busy_o}); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({in_ready_o, mul_start_o, out_valid_o, busy_o} !== 4'b1000)
      begin n_bad++; $display("FAIL rstmid_ctrl: got %b, expected 1000", {in_ready_o, mul_start_o, out_valid_o, busy_o}); end
    n_cmp++; if ({mul_a_o, mul_b_o, out_flags_o, out_product_o} !== 101'h0)
      begin n_bad++; $display("FAIL rstmid_data: got %h, expected 0", {mul_a_o, mul_b_o, out_flags_o, out_product_o}); end
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    f_product = $urandom; f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if ({out_valid_o, mul_start_o, busy_o} !== 3'b000)
        begin n_bad++; $display("FAIL rstmid_late_done[%0d]: got %b, expected 000", i, {out_valid_o, mul_start_o, busy_o}); end
    end
    out_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_nan();
    test_stale_done();
`ifdef FPMUL_DRV_TIMEOUT_EN
    test_timeout();
`endif
    test_random_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
